// File: rtl/rgb_fade_sequencer_pkg.sv
// Shared constants, state encoding and table entry type for the RGB fade sequencer.
package rgb_fade_sequencer_pkg;

    localparam int unsigned TABLE_DEPTH = 4;
    localparam int unsigned COLOR_W     = 8;
    localparam int unsigned ADDR_W      = $clog2(TABLE_DEPTH);
    localparam int unsigned ENTRY_W     = 3 * COLOR_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StFade = 2'd2
    } state_e;

    // Packed {r, g, b}
    typedef logic [ENTRY_W-1:0] entry_t;

endpackage

// File: rtl/rgb_fade_sequencer_if.sv
// Control, table-write and color/status signals of the fade sequencer.
interface rgb_fade_sequencer_if;
    import rgb_fade_sequencer_pkg::*;

    logic               sync_i;
    logic               start_i;
    logic               stop_i;
    logic               loop_i;
    logic [7:0]         hold_i;
    logic               wr_en_i;
    logic [ADDR_W-1:0]  wr_addr_i;
    logic [ENTRY_W-1:0] wr_data_i;
    logic [COLOR_W-1:0] rcolor_o;
    logic [COLOR_W-1:0] gcolor_o;
    logic [COLOR_W-1:0] bcolor_o;
    logic               busy_o;
    logic               seg_done_o;
    logic               done_o;

    modport master (
        output sync_i, start_i, stop_i, loop_i, hold_i, wr_en_i, wr_addr_i, wr_data_i,
        input  rcolor_o, gcolor_o, bcolor_o, busy_o, seg_done_o, done_o
    );

    modport slave (
        input  sync_i, start_i, stop_i, loop_i, hold_i, wr_en_i, wr_addr_i, wr_data_i,
        output rcolor_o, gcolor_o, bcolor_o, busy_o, seg_done_o, done_o
    );

endinterface

// File: rtl/color_stepper8.sv
// One color channel: loadable register that walks one LSB toward a target per step.
module color_stepper8
    import rgb_fade_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [COLOR_W-1:0] load_val_i,
    input  logic               step_i,
    input  logic [COLOR_W-1:0] target_i,
    output logic [COLOR_W-1:0] color_o,
    output logic               at_target_o
);

    logic [COLOR_W-1:0] color_q, color_d;

    always_comb begin
        color_d = color_q;
        if (load_i) begin
            color_d = load_val_i;
        end else if (step_i) begin
            // Moving only while unequal gives saturation with no overshoot.
            if (color_q < target_i) begin
                color_d = color_q + 1'b1;
            end else if (color_q > target_i) begin
                color_d = color_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            color_q <= '0;
        end else begin
            color_q <= color_d;
        end
    end

    assign color_o     = color_q;
    assign at_target_o = (color_q == target_i);

endmodule

// File: rtl/rgb_fade_sequencer.sv
// Steps through a 4-entry color table, holding each entry and fading to the next on PWM ticks.
module rgb_fade_sequencer
    import rgb_fade_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    rgb_fade_sequencer_if.slave bus_io
);

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_next;
    logic [7:0]        hold_cnt_q;
    entry_t            target_q;
    entry_t            table_q [TABLE_DEPTH];
    logic              seg_done_q;
    logic              done_q;

    logic [2:0]        at_target;
    logic              all_at_target;
    logic              load_en;
    logic              step_en;
    entry_t            load_val;
    entry_t            color;

    assign idx_next      = idx_q + 1'b1;
    assign all_at_target = &at_target;
    assign load_val      = table_q[0];
    assign load_en       = (state_q == StIdle) && bus_io.start_i && !bus_io.stop_i;
    assign step_en       = (state_q == StFade) && bus_io.sync_i && !bus_io.stop_i
                           && !all_at_target;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TABLE_DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (bus_io.wr_en_i) begin
            table_q[bus_io.wr_addr_i] <= bus_io.wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            hold_cnt_q <= '0;
            target_q   <= '0;
            seg_done_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            seg_done_q <= 1'b0;
            done_q     <= 1'b0;
            if (bus_io.stop_i) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus_io.start_i) begin
                            idx_q      <= '0;
                            hold_cnt_q <= '0;
                            state_q    <= StHold;
                        end
                    end
                    StHold: begin
                        if (hold_cnt_q == bus_io.hold_i) begin
                            if (idx_q == ADDR_W'(TABLE_DEPTH - 1) && !bus_io.loop_i) begin
                                state_q <= StIdle;
                                done_q  <= 1'b1;
                            end else begin
                                target_q <= table_q[idx_next];
                                state_q  <= StFade;
                            end
                        end else if (bus_io.sync_i) begin
                            hold_cnt_q <= hold_cnt_q + 8'd1;
                        end
                    end
                    StFade: begin
                        if (all_at_target) begin
                            seg_done_q <= 1'b1;
                            idx_q      <= idx_next;
                            hold_cnt_q <= '0;
                            state_q    <= StHold;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    color_stepper8 u_step_r (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_en),
        .load_val_i  (load_val[23:16]),
        .step_i      (step_en),
        .target_i    (target_q[23:16]),
        .color_o     (color[23:16]),
        .at_target_o (at_target[2])
    );

    color_stepper8 u_step_g (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_en),
        .load_val_i  (load_val[15:8]),
        .step_i      (step_en),
        .target_i    (target_q[15:8]),
        .color_o     (color[15:8]),
        .at_target_o (at_target[1])
    );

    color_stepper8 u_step_b (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_en),
        .load_val_i  (load_val[7:0]),
        .step_i      (step_en),
        .target_i    (target_q[7:0]),
        .color_o     (color[7:0]),
        .at_target_o (at_target[0])
    );

    assign bus_io.rcolor_o   = color[23:16];
    assign bus_io.gcolor_o   = color[15:8];
    assign bus_io.bcolor_o   = color[7:0];
    assign bus_io.busy_o     = (state_q != StIdle);
    assign bus_io.seg_done_o = seg_done_q;
    assign bus_io.done_o     = done_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_rgb_fade_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    rgb_fade_sequencer_if bus ();

    rgb_fade_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en  = 1'b0;
    bit sync_rand = 1'b0;
    int sync_cnt  = 0;
    int seg_cnt   = 0;
    int done_cnt  = 0;

    logic [23:0] dut_rgb;
    assign dut_rgb = {bus.rcolor_o, bus.gcolor_o, bus.bcolor_o};

    // Behavioural model: mode 0 idle, 1 holding, 2 fading
    int          m_mode;
    int          m_idx;
    int          m_cnt;
    int          m_col [3];
    int          m_tgt [3];
    logic [23:0] m_tab [4];
    bit          m_seg;
    bit          m_done;

    function automatic int chan(input logic [23:0] e, input int c);
        logic [7:0] v;
        v = e[8*(2-c) +: 8];
        return int'(v);
    endfunction

    always @(posedge clk) begin
        m_seg  = 1'b0;
        m_done = 1'b0;
        if (!rst) begin
            m_mode = 0;
            m_idx  = 0;
            m_cnt  = 0;
            for (int c = 0; c < 3; c++) begin
                m_col[c] = 0;
                m_tgt[c] = 0;
            end
            for (int e = 0; e < 4; e++) m_tab[e] = '0;
        end else begin
            if (bus.stop_i) begin
                m_mode = 0;
            end else if (m_mode == 0) begin
                if (bus.start_i) begin
                    for (int c = 0; c < 3; c++) m_col[c] = chan(m_tab[0], c);
                    m_idx  = 0;
                    m_cnt  = 0;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                if (m_cnt == int'(bus.hold_i)) begin
                    if (m_idx == 3 && !bus.loop_i) begin
                        m_mode = 0;
                        m_done = 1'b1;
                    end else begin
                        for (int c = 0; c < 3; c++) m_tgt[c] = chan(m_tab[(m_idx + 1) % 4], c);
                        m_mode = 2;
                    end
                end else if (bus.sync_i) begin
                    m_cnt = (m_cnt + 1) % 256;
                end
            end else begin
                if (m_col[0] == m_tgt[0] && m_col[1] == m_tgt[1] && m_col[2] == m_tgt[2]) begin
                    m_seg  = 1'b1;
                    m_idx  = (m_idx + 1) % 4;
                    m_cnt  = 0;
                    m_mode = 1;
                end else if (bus.sync_i) begin
                    for (int c = 0; c < 3; c++) begin
                        if (m_col[c] < m_tgt[c]) m_col[c]++;
                        else if (m_col[c] > m_tgt[c]) m_col[c]--;
                    end
                end
            end
            if (bus.wr_en_i) m_tab[bus.wr_addr_i] = bus.wr_data_i;
        end
    end

    always @(negedge clk) begin
        logic [26:0] exp_v;
        logic [26:0] act_v;
        if (check_en) begin
            exp_v = {8'(m_col[0]), 8'(m_col[1]), 8'(m_col[2]), m_mode != 0, m_seg, m_done};
            act_v = {dut_rgb, bus.busy_o, bus.seg_done_o, bus.done_o};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_err++;
                $display("FAIL model t=%0t: rgb/busy/seg/done got %h/%b/%b/%b expected %h/%b/%b/%b",
                         $time, act_v[26:3], act_v[2], act_v[1], act_v[0],
                         exp_v[26:3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
        if (bus.seg_done_o === 1'b1) seg_cnt++;
        if (bus.done_o === 1'b1) done_cnt++;
    end

    always @(negedge clk) begin
        sync_cnt++;
        bus.sync_i = sync_rand ? ($urandom_range(0, 2) == 0) : (sync_cnt % 2 == 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // kind 0: seg_done, 1: done, 2: blue channel == val
    task automatic wait_for(input int kind, input logic [7:0] val, input int bound,
                            input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            case (kind)
                0:       hit = bus.seg_done_o;
                1:       hit = bus.done_o;
                default: hit = (bus.bcolor_o == val);
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no event within %0d cycles", name, bound);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = a;
        bus.wr_data_i = d;
        @(negedge clk);
        bus.wr_en_i = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop_i = 1'b1;
        @(negedge clk);
        bus.stop_i = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start_i   = 1'b0;
        bus.stop_i    = 1'b0;
        bus.loop_i    = 1'b0;
        bus.hold_i    = 8'd0;
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        rst = 1'b0;
        cyc(3);
        check_en = 1'b1;
        chk("reset_busy", 32'(bus.busy_o), 32'd0);
        chk("reset_rgb", 32'(dut_rgb), 32'h000000);
        chk("reset_pulses", 32'({bus.seg_done_o, bus.done_o}), 32'd0);
        rst = 1'b1;

        // Basic start and single-shot completion
        wr(2'd0, 24'hFF0000);
        wr(2'd1, 24'h00FF00);
        wr(2'd2, 24'h0000FF);
        wr(2'd3, 24'hFFFFFF);
        bus.hold_i = 8'd2;
        bus.loop_i = 1'b0;
        seg_cnt  = 0;
        done_cnt = 0;
        pulse_start();
        chk("start_rgb", 32'(dut_rgb), 32'hFF0000);
        chk("start_busy", 32'(bus.busy_o), 32'd1);
        wait_for(0, 8'h00, 1200, "first_seg");
        chk("first_seg_rgb", 32'(dut_rgb), 32'h00FF00);
        wait_for(1, 8'h00, 3000, "single_done");
        chk("done_rgb", 32'(dut_rgb), 32'hFFFFFF);
        chk("done_busy", 32'(bus.busy_o), 32'd0);
        cyc(20);
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("seg_count", 32'(seg_cnt), 32'd3);

        // Loop wrap back to entry 0
        wr(2'd0, 24'h000000);
        wr(2'd1, 24'h000004);
        wr(2'd2, 24'h000008);
        wr(2'd3, 24'h000010);
        bus.hold_i = 8'd0;
        bus.loop_i = 1'b1;
        done_cnt = 0;
        pulse_start();
        for (int k = 0; k < 4; k++) wait_for(0, 8'h00, 200, "loop_seg");
        chk("wrap_rgb", 32'(dut_rgb), 32'h000000);
        chk("wrap_busy", 32'(bus.busy_o), 32'd1);
        cyc(1);
        chk("wrap_no_done", 32'(done_cnt), 32'd0);
        pulse_stop();
        chk("loop_stop_busy", 32'(bus.busy_o), 32'd0);

        // Stop mid-fade freezes color; stop beats start
        wr(2'd1, 24'h0000FF);
        bus.loop_i = 1'b0;
        pulse_start();
        wait_for(2, 8'h40, 400, "reach_b40");
        pulse_stop();
        chk("stop_busy", 32'(bus.busy_o), 32'd0);
        chk("stop_b", 32'(bus.bcolor_o), 32'h40);
        cyc(10);
        chk("stop_b_held", 32'(bus.bcolor_o), 32'h40);
        bus.start_i = 1'b1;
        bus.stop_i  = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        chk("stop_wins", 32'(bus.busy_o), 32'd0);

        // Table write during fade does not move the endpoint
        wr(2'd1, 24'h000020);
        wr(2'd2, 24'h000000);
        wr(2'd3, 24'h000000);
        bus.loop_i = 1'b1;
        pulse_start();
        wait_for(2, 8'h08, 200, "reach_b08");
        wr(2'd1, 24'h000005);
        wait_for(0, 8'h00, 200, "wr_fade_seg");
        chk("wr_fade_end", 32'(dut_rgb), 32'h000020);
        for (int k = 0; k < 4; k++) wait_for(0, 8'h00, 200, "next_lap_seg");
        chk("next_lap_rgb", 32'(dut_rgb), 32'h000005);
        pulse_stop();

        // Reset mid-hold clears everything including the table
        wr(2'd0, 24'h123456);
        bus.loop_i = 1'b0;
        bus.hold_i = 8'd200;
        pulse_start();
        cyc(5);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_rgb", 32'(dut_rgb), 32'h000000);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        pulse_start();
        chk("rst_start_rgb", 32'(dut_rgb), 32'h000000);
        chk("rst_start_busy", 32'(bus.busy_o), 32'd1);
        pulse_stop();

        // Randomized traffic, checked every cycle by the model
        sync_rand = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            bus.start_i = ($urandom_range(0, 19) == 0);
            bus.stop_i  = ($urandom_range(0, 99) == 0);
            bus.wr_en_i = ($urandom_range(0, 5) == 0);
            bus.wr_addr_i = 2'($urandom_range(0, 3));
            bus.wr_data_i = ($urandom_range(0, 1) == 0) ? 24'($urandom)
                                                        : 24'($urandom_range(0, 15) * 'h010101);
            if ($urandom_range(0, 49) == 0) bus.loop_i = ~bus.loop_i;
            if ($urandom_range(0, 29) == 0) bus.hold_i = 8'($urandom_range(0, 4));
            rst = ($urandom_range(0, 799) != 0);
            @(negedge clk);
        end
        bus.start_i = 1'b0;
        bus.stop_i  = 1'b0;
        bus.wr_en_i = 1'b0;
        rst = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_fade_sequencer.md
RGB_FADE_SEQUENCER -- requirements
Module: rgb_fade_sequencer

Interface
REQ-001 The block SHALL use one clock and one reset: clock `clk`, reset `rst`, synchronous and active-low.
REQ-002 Port `clk`, input, 1 bit: rising-edge clock shared with the PWM LED driver.
REQ-003 Port `rst`, input, 1 bit: synchronous active-low reset.
REQ-004 Port `sync_i`, input, 1 bit: one-`clk`-wide strobe per PWM period, taken from the driver's `sync`; one strobe is one tick.
REQ-005 Port `start_i`, input, 1 bit: one-cycle request to begin a sequence.
REQ-006 Port `stop_i`, input, 1 bit: one-cycle request to abort to IDLE.
REQ-007 Port `loop_i`, input, 1 bit: 1 = repeat the sequence forever; 0 = play it once.
REQ-008 Port `hold_i`, input, 8 bits: number of ticks each entry is held.
REQ-009 Port `wr_en_i`, input, 1 bit: color-table write strobe.
REQ-010 Port `wr_addr_i`, input, 2 bits: color-table entry index.
REQ-011 Port `wr_data_i`, input, 24 bits: entry value, packed {r[23:16], g[15:8], b[7:0]}.
REQ-012 Ports `rcolor_o`, `gcolor_o`, `bcolor_o`, output, 8 bits each: current color, fed to the driver's color inputs.
REQ-013 Port `busy_o`, output, 1 bit: high whenever state is not IDLE.
REQ-014 Port `seg_done_o`, output, 1 bit: one-cycle pulse when a fade reaches its target.
REQ-015 Port `done_o`, output, 1 bit: one-cycle pulse when a non-looping sequence finishes.

Function
REQ-016 The color table SHALL hold 4 entries x 24 bits.
- A write takes effect on the `clk` edge where `wr_en_i` = 1.
- Writes are allowed in any state.
REQ-017 The state machine SHALL have three states: IDLE, HOLD and FADE.
REQ-018 In IDLE, `start_i` = 1 SHALL, on the next edge:
- load entry 0 into the color outputs;
- set idx = 0;
- clear the hold counter;
- enter HOLD.
REQ-019 In HOLD, the hold counter SHALL increment on each `sync_i`. When counter == `hold_i`:
- if idx == 3 and `loop_i` = 0, go to IDLE and pulse `done_o` for one cycle;
- otherwise latch target = entry[(idx+1) mod 4] and enter FADE.
REQ-020 When `hold_i` = 0, HOLD SHALL exit on the first edge after entry without waiting for a tick.
REQ-021 In FADE, on each `sync_i`, every channel SHALL step 1 LSB toward its latched target.
- A channel already equal to its target does not move.
- There is no overshoot and no wrap.
REQ-022 When all three channels equal the target (checked every `clk`), the block SHALL, on that edge:
- pulse `seg_done_o`;
- set idx = (idx+1) mod 4, wrapping 3 to 0;
- clear the hold counter;
- enter HOLD.
REQ-023 The target SHALL be latched on FADE entry; table writes during FADE SHALL NOT alter the fade in progress.
REQ-024 If the target equals the current color, FADE SHALL complete on the next edge with zero ticks consumed.
REQ-025 A fade SHALL take at most 255 ticks, set by the largest per-channel difference.
REQ-026 `start_i` while busy SHALL be ignored.
REQ-027 `stop_i` in any state SHALL force IDLE on the next edge.
- Color outputs freeze at their present value.
- No `done_o` pulse is issued.
REQ-028 If `stop_i` and `start_i` are asserted in the same cycle, `stop_i` SHALL win.
REQ-029 Color outputs SHALL hold their value in IDLE.
REQ-030 `loop_i` and `hold_i` SHALL be sampled live; a change applies at the next comparison.

Reset
REQ-031 On `rst` = 0 at a `clk` edge, the block SHALL enter IDLE and set:
- idx = 0 and hold counter = 0;
- all color outputs = 8'h00;
- `busy_o`, `seg_done_o` and `done_o` = 0.
REQ-032 Reset SHALL clear all table entries to 24'h000000.
REQ-033 Reset mid-FADE or mid-HOLD SHALL abandon the sequence with no `done_o` pulse.

Structure
REQ-034 A shared package SHALL hold:
- the constants TABLE_DEPTH = 4 and COLOR_W = 8;
- the 2-bit state encoding (IDLE = 0, HOLD = 1, FADE = 2).
REQ-035 One sub-module, `color_stepper8`, SHALL be instantiated three times. Per channel it provides:
- the one-LSB saturating step toward target on a tick;
- an at-target flag.
REQ-036 All state SHALL be clocked by `clk` only; no other signal SHALL be used as a clock.

Verification
REQ-037 Basic start: table = {FF0000, 00FF00, 0000FF, FFFFFF}, `hold_i` = 2, `loop_i` = 0, start.
- Outputs = FF/00/00 on the next cycle.
- After 2 ticks, FADE begins.
- After 255 ticks, outputs = 00/FF/00 with one `seg_done_o` pulse.
REQ-038 Single-shot completion: continuing REQ-037 to entry 3 plus its hold, `done_o` pulses exactly once and `busy_o` falls with outputs = FF/FF/FF.
REQ-039 Loop wrap: `loop_i` = 1, entry 3 = 000010, entry 0 = 000000, `hold_i` = 0. After entry 3, the sequence fades to 000000 in 16 ticks, idx wraps to 0, and there is no `done_o` pulse.
REQ-040 Stop precedence: `stop_i` mid-FADE at b = 8'h40 gives IDLE on the next edge with b frozen at 40. Simultaneous `start_i` + `stop_i` in IDLE leaves `busy_o` = 0.
REQ-041 Write during fade: writing the current target entry mid-FADE leaves the fade endpoint unchanged. The new value is used on the next lap.
REQ-042 Reset mid-run: `rst` = 0 for one cycle mid-HOLD gives all outputs = 0 and IDLE. A following `start_i` outputs entry 0 = 000000.
